// File: rtl/shot_resolver.sv
// Resolves one shot against a 12x12 board: reads the cell, classifies it, writes back and reports.
// Optional miss counter enabled by defining SHOT_RESOLVER_MISS_CNT_EN (otherwise miss_count is tied to 0).
module shot_resolver #(
   parameter int X_SIZE     = 12,
   parameter int Y_SIZE     = 12,
   parameter int SHIP_CELLS = 20,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 new_game,
   input  logic                 shot_valid,
   output logic                 shot_ready,
   input  logic [3:0]           shot_x,
   input  logic [3:0]           shot_y,
   output logic [7:0]           mem_read_addr,
   input  logic [1:0]           mem_read_data,
   output logic [7:0]           mem_write_addr,
   output logic [1:0]           mem_write_data,
   output logic                 mem_write_enable,
   output logic                 result_valid,
   output logic [1:0]           result_code,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic                 game_over
);
   typedef enum logic [1:0] {IDLE, WAIT, EVAL, RESP} state_t;

   localparam logic [1:0] CELL_EMPTY  = 2'b00;
   localparam logic [1:0] CELL_SHIP   = 2'b01;
   localparam logic [1:0] CELL_MISSED = 2'b10;
   localparam logic [1:0] CELL_HIT    = 2'b11;
   localparam logic [1:0] RES_MISS    = 2'b00;
   localparam logic [1:0] RES_HIT     = 2'b01;
   localparam logic [1:0] RES_REPEAT  = 2'b10;
   localparam logic [1:0] RES_INVALID = 2'b11;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   state_t               state_q, state_d;
   logic [3:0]           x_q, x_d, y_q, y_d;
   logic                 invalid_q, invalid_d;
   logic [7:0]           rd_addr_q, rd_addr_d;
   logic                 res_valid_q, res_valid_d;
   logic [1:0]           res_code_q, res_code_d;
   logic                 wr_en_q, wr_en_d;
   logic [7:0]           wr_addr_q, wr_addr_d;
   logic [1:0]           wr_data_q, wr_data_d;
   logic [CNT_WIDTH-1:0] hit_q, hit_d;
   logic                 game_over_q, game_over_d;
   logic [1:0]           eval_code;
   logic                 eval_miss;

   assign shot_ready = (state_q == IDLE) && !game_over_q;

   always_comb begin
      eval_code = RES_REPEAT;
      if (invalid_q)                          eval_code = RES_INVALID;
      else if (mem_read_data == CELL_EMPTY)   eval_code = RES_MISS;
      else if (mem_read_data == CELL_SHIP)    eval_code = RES_HIT;
   end

   assign eval_miss = (state_q == EVAL) && (eval_code == RES_MISS);

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      invalid_d   = invalid_q;
      rd_addr_d   = rd_addr_q;
      res_valid_d = 1'b0;
      res_code_d  = res_code_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      hit_d       = hit_q;
      game_over_d = game_over_q;
      if (new_game) begin
         state_d     = IDLE;
         hit_d       = '0;
         game_over_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (shot_valid && shot_ready) begin
               x_d       = shot_x;
               y_d       = shot_y;
               rd_addr_d = {shot_x, shot_y};
               invalid_d = (32'(shot_x) >= X_SIZE) || (32'(shot_y) >= Y_SIZE);
               state_d   = WAIT;
            end
            WAIT: state_d = EVAL;
            EVAL: begin
               state_d     = RESP;
               res_valid_d = 1'b1;
               res_code_d  = eval_code;
               wr_addr_d   = {x_q, y_q};
               wr_en_d     = (eval_code == RES_MISS) || (eval_code == RES_HIT);
               wr_data_d   = (eval_code == RES_HIT) ? CELL_HIT : CELL_MISSED;
               if (eval_code == RES_HIT) begin
                  if (hit_q != CNT_MAX) hit_d = hit_q + 1'b1;
                  if (hit_d == CNT_WIDTH'(SHIP_CELLS)) game_over_d = 1'b1;
               end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         invalid_q   <= 1'b0;
         rd_addr_q   <= '0;
         res_valid_q <= 1'b0;
         res_code_q  <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         hit_q       <= '0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         invalid_q   <= invalid_d;
         rd_addr_q   <= rd_addr_d;
         res_valid_q <= res_valid_d;
         res_code_q  <= res_code_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         hit_q       <= hit_d;
         game_over_q <= game_over_d;
      end
   end

`ifdef SHOT_RESOLVER_MISS_CNT_EN
   logic [CNT_WIDTH-1:0] miss_q, miss_d;

   always_comb begin
      miss_d = miss_q;
      if (new_game)                          miss_d = '0;
      else if (eval_miss && miss_q != CNT_MAX) miss_d = miss_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) miss_q <= '0;
      else     miss_q <= miss_d;
   end

   assign miss_count = miss_q;
`else
   logic unused_miss;
   assign unused_miss = eval_miss;
   assign miss_count  = '0;
`endif

   // A new_game arriving during RESP must suppress the pending result and board write.
   assign result_valid     = res_valid_q && !new_game;
   assign mem_write_enable = wr_en_q && !new_game;
   assign result_code      = res_code_q;
   assign mem_write_addr   = wr_addr_q;
   assign mem_write_data   = wr_data_q;
   assign mem_read_addr    = rd_addr_q;
   assign hit_count        = hit_q;
   assign game_over        = game_over_q;
endmodule

// File: tb/tb_shot_resolver.sv
// Directed self-checking bench for shot_resolver with a behavioural board_mem model.
module tb_shot_resolver;
   logic       clk, rst, new_game, shot_valid, shot_ready;
   logic [3:0] shot_x, shot_y;
   logic [7:0] mem_read_addr, mem_write_addr;
   logic [1:0] mem_read_data, mem_write_data, result_code;
   logic       mem_write_enable, result_valid, game_over;
   logic [4:0] hit_count, miss_count;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef SHOT_RESOLVER_MISS_CNT_EN
   localparam bit MISS_EN = 1'b1;
`else
   localparam bit MISS_EN = 1'b0;
`endif

   shot_resolver dut (
      .clk(clk), .rst(rst), .new_game(new_game),
      .shot_valid(shot_valid), .shot_ready(shot_ready),
      .shot_x(shot_x), .shot_y(shot_y),
      .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
      .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
      .mem_write_enable(mem_write_enable),
      .result_valid(result_valid), .result_code(result_code),
      .hit_count(hit_count), .miss_count(miss_count), .game_over(game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // board_mem model: registered read, synchronous write, plus a bench preload port
   logic [1:0] board [256];
   logic       clr, pre_we;
   logic [7:0] pre_addr;
   logic [1:0] pre_data;
   always @(posedge clk) begin
      mem_read_data <= board[mem_read_addr];
      if (clr) begin
         for (int i = 0; i < 256; i++) board[i] <= 2'b00;
      end else if (mem_write_enable) begin
         board[mem_write_addr] <= mem_write_data;
      end else if (pre_we) begin
         board[pre_addr] <= pre_data;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] em(input int n);
      return MISS_EN ? 5'(n) : 5'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [1:0] d);
      pre_addr = a; pre_data = d; pre_we = 1'b1;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic wait_ready();
      for (int n = 0; n < 10 && !shot_ready; n++) tick();
      if (!shot_ready) check_eq("ready_timeout", 32'(shot_ready), 32'd1);
   endtask

   // Full shot: accept at E0, result checked after E2, return to IDLE after E3.
   task automatic do_shot(input logic [3:0] x, input logic [3:0] y, input logic [1:0] code,
                          input int hits, input logic [4:0] misses);
      logic go;
      go = (hits == 20);
      wait_ready();
      shot_x = x; shot_y = y; shot_valid = 1'b1;
      tick();
      shot_valid = 1'b0;
      check_eq("read_addr", 32'(mem_read_addr), 32'({x, y}));
      check_eq("ready_e0", 32'(shot_ready), 32'd0);
      tick();
      check_eq("ready_e1", 32'(shot_ready), 32'd0);
      check_eq("rv_e1", 32'(result_valid), 32'd0);
      tick();
      check_eq("rv_e2", 32'(result_valid), 32'd1);
      check_eq("code", 32'(result_code), 32'(code));
      check_eq("we", 32'(mem_write_enable), 32'(code == 2'b00 || code == 2'b01));
      if (code == 2'b00 || code == 2'b01) begin
         check_eq("waddr", 32'(mem_write_addr), 32'({x, y}));
         check_eq("wdata", 32'(mem_write_data), (code == 2'b01) ? 32'd3 : 32'd2);
      end
      check_eq("hits", 32'(hit_count), 32'(hits));
      check_eq("misses", 32'(miss_count), 32'(misses));
      check_eq("game_over", 32'(game_over), 32'(go));
      check_eq("ready_e2", 32'(shot_ready), 32'd0);
      tick();
      check_eq("rv_e3", 32'(result_valid), 32'd0);
      check_eq("we_e3", 32'(mem_write_enable), 32'd0);
      check_eq("ready_e3", 32'(shot_ready), 32'(!go));
   endtask

   logic [1:0] b2b_code [4];
   int h;

   initial begin
      rst = 1'b1; new_game = 1'b0; shot_valid = 1'b0; shot_x = '0; shot_y = '0;
      clr = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      #1;
      check_eq("rst_ready", 32'(shot_ready), 32'd1);
      check_eq("rst_rv", 32'(result_valid), 32'd0);
      check_eq("rst_we", 32'(mem_write_enable), 32'd0);
      check_eq("rst_hits", 32'(hit_count), 32'd0);
      check_eq("rst_misses", 32'(miss_count), 32'd0);
      check_eq("rst_go", 32'(game_over), 32'd0);
      check_eq("rst_raddr", 32'(mem_read_addr), 32'd0);
      clr = 1'b1;
      tick(); tick();
      clr = 1'b0;
      rst = 1'b0;
      preload(8'h35, 2'b01);
      for (int x = 5; x <= 9; x++)
         for (int y = 0; y <= 3; y++)
            if (!(x == 9 && y == 3)) preload({4'(x), 4'(y)}, 2'b01);

      // hit, repeat, miss, repeat, invalid column, invalid row
      do_shot(4'd3, 4'd5, 2'b01, 1, em(0));
      check_eq("board_35", 32'(board[8'h35]), 32'd3);
      do_shot(4'd3, 4'd5, 2'b10, 1, em(0));
      do_shot(4'd0, 4'd0, 2'b00, 1, em(1));
      check_eq("board_00", 32'(board[8'h00]), 32'd2);
      do_shot(4'd0, 4'd0, 2'b10, 1, em(1));
      do_shot(4'd12, 4'd4, 2'b11, 1, em(1));
      do_shot(4'd4, 4'd15, 2'b11, 1, em(1));

      // sink the remaining 19 ship cells; the 20th hit raises game_over
      h = 1;
      for (int x = 5; x <= 9; x++)
         for (int y = 0; y <= 3; y++)
            if (!(x == 9 && y == 3)) begin
               h++;
               do_shot(4'(x), 4'(y), 2'b01, h, em(1));
            end
      shot_x = 4'd0; shot_y = 4'd2; shot_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("go_ready_held", 32'(shot_ready), 32'd0);
         check_eq("go_rv_held", 32'(result_valid), 32'd0);
      end
      shot_valid = 1'b0;
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      check_eq("ng_hits", 32'(hit_count), 32'd0);
      check_eq("ng_misses", 32'(miss_count), 32'd0);
      check_eq("ng_go", 32'(game_over), 32'd0);
      check_eq("ng_ready", 32'(shot_ready), 32'd1);

      // new_game during WAIT aborts the shot
      shot_x = 4'd0; shot_y = 4'd1; shot_valid = 1'b1;
      tick();
      shot_valid = 1'b0;
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      check_eq("abort_wait_ready", 32'(shot_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         check_eq("abort_wait_rv", 32'(result_valid), 32'd0);
         check_eq("abort_wait_we", 32'(mem_write_enable), 32'd0);
         tick();
      end
      check_eq("abort_wait_board", 32'(board[8'h01]), 32'd0);

      // new_game during RESP suppresses the pending result and write
      shot_x = 4'd2; shot_y = 4'd2; shot_valid = 1'b1;
      tick();
      shot_valid = 1'b0;
      tick(); tick();
      check_eq("resp_rv_pre", 32'(result_valid), 32'd1);
      new_game = 1'b1;
      #1;
      check_eq("resp_ng_rv", 32'(result_valid), 32'd0);
      check_eq("resp_ng_we", 32'(mem_write_enable), 32'd0);
      tick();
      new_game = 1'b0;
      check_eq("resp_ng_board", 32'(board[8'h22]), 32'd0);
      check_eq("resp_ng_ready", 32'(shot_ready), 32'd1);
      check_eq("resp_ng_misses", 32'(miss_count), 32'd0);

      // rst during RESP clears outputs immediately
      shot_x = 4'd1; shot_y = 4'd1; shot_valid = 1'b1;
      tick();
      shot_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      check_eq("rst_resp_rv", 32'(result_valid), 32'd0);
      check_eq("rst_resp_we", 32'(mem_write_enable), 32'd0);
      check_eq("rst_resp_misses", 32'(miss_count), 32'd0);
      check_eq("rst_resp_raddr", 32'(mem_read_addr), 32'd0);
      check_eq("rst_resp_ready", 32'(shot_ready), 32'd1);
      tick();
      rst = 1'b0;
      tick();
      check_eq("rst_resp_board", 32'(board[8'h11]), 32'd0);
      check_eq("rst_resp_rv2", 32'(result_valid), 32'd0);

      // back-to-back: shot_valid held, coordinates (i,7) change every cycle
      preload(8'h47, 2'b01);
      b2b_code[0] = 2'b00; b2b_code[1] = 2'b01; b2b_code[2] = 2'b00; b2b_code[3] = 2'b11;
      for (int i = 0; i < 16; i++) begin
         shot_x = 4'(i); shot_y = 4'd7; shot_valid = 1'b1;
         tick();
         check_eq("b2b_ready", 32'(shot_ready), 32'(i % 4 == 3));
         check_eq("b2b_rv", 32'(result_valid), 32'(i % 4 == 2));
         if (i % 4 == 0) check_eq("b2b_raddr", 32'(mem_read_addr), 32'({4'(i), 4'd7}));
         if (i % 4 == 2) begin
            check_eq("b2b_code", 32'(result_code), 32'(b2b_code[i / 4]));
            if (i != 14) check_eq("b2b_waddr", 32'(mem_write_addr), 32'({4'(i - 2), 4'd7}));
         end
      end
      shot_valid = 1'b0;
      check_eq("b2b_hits", 32'(hit_count), 32'd1);
      check_eq("b2b_misses", 32'(miss_count), 32'(em(2)));
      check_eq("b2b_board47", 32'(board[8'h47]), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
